// File: rtl/mindu_pkg.sv
// rtl/mindu_pkg.sv - shared types and constants for the base-20 Mindu counter
package mindu_pkg;

    typedef logic [4:0] mindu_digit_t;

    localparam mindu_digit_t MINDU_MAX = 5'd19;
    localparam mindu_digit_t BANANA_HI = 5'd10;
    localparam mindu_digit_t BANANA_LO = 5'd7;

    typedef enum logic [1:0] {IDLE, RUN, HALT} mcnt_state_t;

    // Illegal digit codes collapse to zero so count never shows a non-Mindu digit.
    function automatic mindu_digit_t sanitize(input mindu_digit_t d, input mindu_digit_t radix);
        return (d < radix) ? d : '0;
    endfunction

endpackage

// File: rtl/mindu_digit.sv
// rtl/mindu_digit.sv - one base-20 digit register with load, increment and decrement
module mindu_digit
    import mindu_pkg::*;
#(
    parameter int RADIX = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       ld,
    input  logic [4:0] ld_val,
    output logic [4:0] digit,
    output logic       carry,
    output logic       borrow
);

    localparam mindu_digit_t TOP = mindu_digit_t'(RADIX - 1);

    // Carry/borrow are combinational so the next digit up steps on the same edge.
    assign carry  = inc && (digit == TOP);
    assign borrow = dec && (digit == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (ld) begin
            digit <= ld_val;
        end else if (inc) begin
            digit <= carry ? '0 : digit + 5'd1;
        end else if (dec) begin
            digit <= borrow ? TOP : digit - 5'd1;
        end
    end

endmodule

// File: rtl/mindu_counter.sv
// rtl/mindu_counter.sv - two-digit base-20 up/down counter with prescaler and FSM
// Optional BANANA_STOP_EN: halt counting when a step lands on {10,7}.
module mindu_counter
    import mindu_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int RADIX    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [9:0] load_val,
    output logic [9:0] count,
    output logic       tick,
    output logic       wrap,
    output logic       load_err
);

    localparam int           PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam mindu_digit_t RADIX_D  = mindu_digit_t'(RADIX);

    mcnt_state_t   state;
    mcnt_state_t   state_next;
    logic [PW-1:0] pre;
    logic          pre_last;
    logic          tick_raw;
    logic          step;
    logic          ld_any;
    logic          ld_bad;
    mindu_digit_t  lo;
    mindu_digit_t  hi;
    mindu_digit_t  ld_lo;
    mindu_digit_t  ld_hi;
    logic          lo_carry;
    logic          lo_borrow;
    logic          hi_carry;
    logic          hi_borrow;

    // clr and load win over the prescaler expiry, so no tick or step that cycle.
    assign pre_last = run && (pre == PRE_LAST);
    assign tick_raw = pre_last && !clr && !load;
    assign step     = tick_raw && (state == RUN);

    assign ld_any = clr || load;
    assign ld_bad = (load_val[9:5] >= RADIX_D) || (load_val[4:0] >= RADIX_D);
    assign ld_hi  = clr ? '0 : sanitize(load_val[9:5], RADIX_D);
    assign ld_lo  = clr ? '0 : sanitize(load_val[4:0], RADIX_D);

    mindu_digit #(.RADIX(RADIX)) u_lo (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (step && up),
        .dec    (step && !up),
        .ld     (ld_any),
        .ld_val (ld_lo),
        .digit  (lo),
        .carry  (lo_carry),
        .borrow (lo_borrow)
    );

    mindu_digit #(.RADIX(RADIX)) u_hi (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (lo_carry),
        .dec    (lo_borrow),
        .ld     (ld_any),
        .ld_val (ld_hi),
        .digit  (hi),
        .carry  (hi_carry),
        .borrow (hi_borrow)
    );

    assign count = {hi, lo};

`ifdef BANANA_STOP_EN
    logic halt_hit;
    // The only neighbours of {10,7} are {10,6} going up and {10,8} going down.
    assign halt_hit = step && (hi == BANANA_HI) &&
                      (up ? (lo == BANANA_LO - 5'd1) : (lo == BANANA_LO + 5'd1));
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run) state_next = RUN;
            end
            RUN: begin
                if (!run) begin
                    state_next = IDLE;
`ifdef BANANA_STOP_EN
                end else if (halt_hit) begin
                    state_next = HALT;
`endif
                end
            end
`ifdef BANANA_STOP_EN
            HALT: begin
                if (ld_any) state_next = run ? RUN : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pre      <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            tick     <= tick_raw;
            wrap     <= hi_carry || hi_borrow;
            load_err <= load && !clr && ld_bad;
            // Holding pre while run is low keeps a paused period phase-continuous.
            if (ld_any) begin
                pre <= '0;
            end else if (run) begin
                pre <= pre_last ? '0 : pre + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mindu_counter.sv
// tb/tb_mindu_counter.sv - scoreboard bench for mindu_counter with TICK_DIV=4
module tb_mindu_counter;

    localparam int TICK_DIV = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       run      = 1'b0;
    logic       up       = 1'b1;
    logic       clr      = 1'b0;
    logic       load     = 1'b0;
    logic [9:0] load_val = '0;
    logic [9:0] count;
    logic       tick;
    logic       wrap;
    logic       load_err;

    mindu_counter #(.TICK_DIV(TICK_DIV), .RADIX(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] count;
        logic       tick;
        logic       wrap;
        logic       load_err;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expectations are timestamped; the monitor checks them at the falling edge of their cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || count !== e.count || tick !== e.tick ||
                wrap !== e.wrap || load_err !== e.load_err) begin
                errors++;
                $display("FAIL %s: cycle %0d got hi=%0d lo=%0d tick=%b wrap=%b load_err=%b, want cycle %0d hi=%0d lo=%0d tick=%b wrap=%b load_err=%b",
                         e.name, cyc, count[9:5], count[4:0], tick, wrap, load_err,
                         e.cyc, e.count[9:5], e.count[4:0], e.tick, e.wrap, e.load_err);
            end
        end
    end

    task automatic expect_at(input int d, input logic [4:0] h, input logic [4:0] l,
                             input logic t, input logic w, input logic le, input string n);
        exp_t x;
        int   i;
        x.cyc      = cyc + d;
        x.count    = {h, l};
        x.tick     = t;
        x.wrap     = w;
        x.load_err = le;
        x.name     = n;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= x.cyc) i++;
        sb.insert(i, x);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] h, input logic [4:0] l);
        load     = 1'b1;
        load_val = {h, l};
        cycles(1);
        load     = 1'b0;
    endtask

    initial begin
        cycles(2);
        expect_at(0, 0, 0, 0, 0, 0, "reset_state");
        rst_n = 1'b1;
        expect_at(3, 0, 0, 0, 0, 0, "idle_hold");
        cycles(3);

        // Up with carry from lo into hi, then full wrap.
        do_load(5'd0, 5'd19);
        expect_at(0, 0, 19, 0, 0, 0, "load_0_19");
        run = 1'b1;
        expect_at(3, 0, 19, 0, 0, 0, "before_first_step");
        expect_at(4, 1, 0, 1, 0, 0, "up_carry");
        cycles(4);
        do_load(5'd19, 5'd19);
        expect_at(0, 19, 19, 0, 0, 0, "load_19_19");
        expect_at(4, 0, 0, 1, 1, 0, "wrap_up");
        expect_at(5, 0, 0, 0, 0, 0, "wrap_up_ends");
        cycles(5);

        // Down with borrow, then full wrap.
        up = 1'b0;
        do_load(5'd3, 5'd0);
        expect_at(0, 3, 0, 0, 0, 0, "load_3_0");
        expect_at(4, 2, 19, 1, 0, 0, "down_borrow");
        cycles(4);
        do_load(5'd0, 5'd0);
        expect_at(0, 0, 0, 0, 0, 0, "load_0_0");
        expect_at(4, 19, 19, 1, 1, 0, "wrap_down");
        expect_at(5, 19, 19, 0, 0, 0, "wrap_down_ends");
        cycles(5);

        // Illegal digit handling.
        run = 1'b0;
        up  = 1'b1;
        do_load(5'd25, 5'd20);
        expect_at(0, 0, 0, 0, 0, 1, "illegal_both");
        expect_at(1, 0, 0, 0, 0, 0, "load_err_ends");
        cycles(1);
        do_load(5'd3, 5'd31);
        expect_at(0, 3, 0, 0, 0, 1, "illegal_lo_only");
        do_load(5'd19, 5'd5);
        expect_at(0, 19, 5, 0, 0, 0, "legal_19_5");

        // clr beats load; pause and phase-continuous resume.
        clr      = 1'b1;
        load     = 1'b1;
        load_val = {5'd4, 5'd4};
        cycles(1);
        clr  = 1'b0;
        load = 1'b0;
        expect_at(0, 0, 0, 0, 0, 0, "clr_over_load");
        run = 1'b1;
        expect_at(2, 0, 0, 0, 0, 0, "pre_pause");
        cycles(2);
        run = 1'b0;
        expect_at(10, 0, 0, 0, 0, 0, "paused");
        cycles(10);
        run = 1'b1;
        expect_at(1, 0, 0, 0, 0, 0, "resume_wait");
        expect_at(2, 0, 1, 1, 0, 0, "resume_step");
        cycles(3);

        // Asynchronous reset mid-count, no clock edge needed.
        rst_n = 1'b0;
        expect_at(0, 0, 0, 0, 0, 0, "async_reset");
        cycles(2);
        run   = 1'b0;
        rst_n = 1'b1;
        expect_at(3, 0, 0, 0, 0, 0, "post_reset_hold");
        cycles(3);

        // Passing through {10,7}.
        run = 1'b1;
        up  = 1'b1;
        do_load(5'd10, 5'd6);
        expect_at(0, 10, 6, 0, 0, 0, "load_10_6");
        expect_at(4, 10, 7, 1, 0, 0, "step_to_10_7");
`ifdef BANANA_STOP_EN
        expect_at(8, 10, 7, 1, 0, 0, "halt_tick_1");
        expect_at(12, 10, 7, 1, 0, 0, "halt_tick_2");
        expect_at(16, 10, 7, 1, 0, 0, "halt_tick_3");
        cycles(16);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        expect_at(0, 0, 0, 0, 0, 0, "halt_clr");
        expect_at(4, 0, 1, 1, 0, 0, "resume_after_halt");
        cycles(4);
`else
        expect_at(8, 10, 8, 1, 0, 0, "pass_10_7");
        cycles(8);
`endif

        for (int i = 0; i < 50 && sb.size() > 0; i++) cycles(1);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations unchecked, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
